// File: rtl/honeyb_pkg.sv
// Purpose: host general-purpose register file layout (command and result views).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package honeyb_pkg;

    localparam int NUM_GPP = 32;

    typedef logic [31:0] gpp_t;

    // Command view (host -> accelerator)
    localparam int CMD      = 0;
    localparam int COUNT    = 1;
    localparam int SRC      = 2;
    localparam int ADDEND   = 3;

    // Result view (accelerator -> host)
    localparam int STATUS     = 0;
    localparam int CHECKSUM   = 1;
    localparam int LINES_DONE = 2;

endpackage

// File: rtl/xlr_mem_pkg.sv
// Purpose: line/word geometry shared by everything that touches accelerator memories.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xlr_mem_pkg;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
    localparam int BE_W           = LINE_W / 8;

    typedef logic [WORD_W-1:0] word_t;
    // Word 0 occupies bits [31:0] of the flattened line.
    typedef word_t [WORDS_PER_LINE-1:0] line_t;

endpackage

// File: rtl/xbox_xlr_dummy1_dp.sv
// Purpose: 8-lane adder (word + addend) plus checksum reduction of the resulting line.
// Latency: combinational, 0 cycles.
// Backpressure: none; caller decides when to consume the outputs.
// Ports: line_in/addend -> line_out (per-word sum mod 2^32), line_sum (sum of line_out words mod 2^32).
module xbox_xlr_dummy1_dp
    import xlr_mem_pkg::*;
(
    input  line_t line_in,
    input  word_t addend,
    output line_t line_out,
    output word_t line_sum
);

    always_comb begin
        line_out = '0;
        line_sum = '0;
        for (int j = 0; j < WORDS_PER_LINE; j++) begin
            word_t w;
            w           = line_in[j] + addend;
            line_out[j] = w;
            line_sum    = line_sum + w;
        end
    end

endmodule

// File: rtl/xbox_xlr_dummy1.sv
// Purpose: reference accelerator; copies N lines mem0[S+i] -> mem1[i] adding K per word, reports checksum.
// Latency: first mem0 read 1 cycle after start, 3 cycles per line, result pulse 1+3N cycles after start.
// Backpressure: none; memories are fixed-latency, starts arriving while busy are dropped.
// Ports: clk/rst_n; per-memory addr/wdata/be/rd/wr out and rdata in; host_regs + valid pulse in;
//        host_regs_data_out + valid pulse out. Memories other than 0 (source) and 1 (dest) are held idle.
module xbox_xlr_dummy1
    import xlr_mem_pkg::*;
    import honeyb_pkg::*;
#(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]    xlr_mem_addr,
    output logic [NUM_MEMS-1:0][LINE_W-1:0]                xlr_mem_wdata,
    output logic [NUM_MEMS-1:0][BE_W-1:0]                  xlr_mem_be,
    output logic [NUM_MEMS-1:0]                            xlr_mem_rd,
    output logic [NUM_MEMS-1:0]                            xlr_mem_wr,
    input  logic [NUM_MEMS-1:0][LINE_W-1:0]                xlr_mem_rdata,
    input  gpp_t [NUM_GPP-1:0]                             host_regs,
    input  logic                                           host_regs_valid_pulse,
    output gpp_t [NUM_GPP-1:0]                             host_regs_data_out,
    output logic                                           host_regs_valid_out
);

    localparam int AW    = LOG2_LINES_PER_MEM;
    localparam int CNT_W = AW + 1;   // N may equal the full memory depth
    localparam logic [CNT_W-1:0] ONE_CNT = 1;

    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WAIT, ST_WR, ST_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] n_lines;
    logic [AW-1:0]    src_base;
    word_t            addend;
    logic [CNT_W-1:0] line_idx;
    word_t            acc;

    logic             rd0_q;
    logic [AW-1:0]    addr0_q;
    logic             wr1_q;
    logic [AW-1:0]    addr1_q;
    line_t            wdata1_q;
    logic [BE_W-1:0]  be1_q;

    line_t            dp_line;
    word_t            dp_sum;

    logic [CNT_W-1:0] cmd_count;
    logic [AW-1:0]    cmd_src;
    logic             cmd_start;
    logic [CNT_W-1:0] idx_nxt;
    logic             unused_ok;

    assign cmd_start = host_regs_valid_pulse && host_regs[CMD][0];
    assign cmd_count = host_regs[COUNT][CNT_W-1:0];
    assign cmd_src   = host_regs[SRC][AW-1:0];
    assign idx_nxt   = line_idx + ONE_CNT;

    assign unused_ok = ^{host_regs[NUM_GPP-1:4], host_regs[CMD][31:1],
                         host_regs[COUNT][31:CNT_W], host_regs[SRC][31:AW],
                         xlr_mem_rdata[NUM_MEMS-1:1]};

    // Read data is live during WAIT; the sum is registered straight into the write port.
    xbox_xlr_dummy1_dp u_dp (
        .line_in  (line_t'(xlr_mem_rdata[0])),
        .addend   (addend),
        .line_out (dp_line),
        .line_sum (dp_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            n_lines             <= '0;
            src_base            <= '0;
            addend              <= '0;
            line_idx            <= '0;
            acc                 <= '0;
            rd0_q               <= 1'b0;
            addr0_q             <= '0;
            wr1_q               <= 1'b0;
            addr1_q             <= '0;
            wdata1_q            <= '0;
            be1_q               <= '0;
            host_regs_data_out  <= '0;
            host_regs_valid_out <= 1'b0;
        end else begin
            // Strobes are single-cycle; address/data/be drop to zero whenever the strobe is low.
            rd0_q               <= 1'b0;
            addr0_q             <= '0;
            wr1_q               <= 1'b0;
            addr1_q             <= '0;
            wdata1_q            <= '0;
            be1_q               <= '0;
            host_regs_valid_out <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        n_lines  <= cmd_count;
                        src_base <= cmd_src;
                        addend   <= host_regs[ADDEND];
                        line_idx <= '0;
                        acc      <= '0;
                        if (cmd_count == '0) begin
                            state                           <= ST_DONE;
                            host_regs_valid_out             <= 1'b1;
                            host_regs_data_out              <= '0;
                            host_regs_data_out[STATUS]      <= 32'd1;
                        end else begin
                            state                           <= ST_RD;
                            rd0_q                           <= 1'b1;
                            addr0_q                         <= cmd_src;
                            host_regs_data_out[STATUS]      <= '0;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    state    <= ST_WR;
                    wr1_q    <= 1'b1;
                    addr1_q  <= line_idx[AW-1:0];
                    be1_q    <= '1;
                    wdata1_q <= dp_line;
                    acc      <= acc + dp_sum;
                end
                ST_WR: begin
                    if (idx_nxt == n_lines) begin
                        state                           <= ST_DONE;
                        host_regs_valid_out             <= 1'b1;
                        host_regs_data_out              <= '0;
                        host_regs_data_out[STATUS]      <= 32'd1;
                        host_regs_data_out[CHECKSUM]    <= acc;
                        host_regs_data_out[LINES_DONE]  <= {{(32-CNT_W){1'b0}}, n_lines};
                    end else begin
                        state    <= ST_RD;
                        line_idx <= idx_nxt;
                        rd0_q    <= 1'b1;
                        // Truncation gives the modulo-depth wrap of the source address.
                        addr0_q  <= src_base + idx_nxt[AW-1:0];
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        xlr_mem_addr     = '0;
        xlr_mem_wdata    = '0;
        xlr_mem_be       = '0;
        xlr_mem_rd       = '0;
        xlr_mem_wr       = '0;
        xlr_mem_rd[0]    = rd0_q;
        xlr_mem_addr[0]  = addr0_q;
        xlr_mem_wr[1]    = wr1_q;
        xlr_mem_addr[1]  = addr1_q;
        xlr_mem_wdata[1] = wdata1_q;
        xlr_mem_be[1]    = be1_q;
    end

endmodule

// File: tb/tb_xbox_xlr_dummy1.sv
// Purpose: directed self-checking bench for xbox_xlr_dummy1 with behavioural source/dest memories.
// Latency: n/a.
// Backpressure: n/a.
module tb_xbox_xlr_dummy1;

    localparam int NM = 2;
    localparam int LG = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NM-1:0][LG-1:0]  xlr_mem_addr;
    logic [NM-1:0][255:0]   xlr_mem_wdata;
    logic [NM-1:0][31:0]    xlr_mem_be;
    logic [NM-1:0]          xlr_mem_rd;
    logic [NM-1:0]          xlr_mem_wr;
    logic [NM-1:0][255:0]   xlr_mem_rdata;
    logic [31:0][31:0]      host_regs = '0;
    logic                   host_regs_valid_pulse = 1'b0;
    logic [31:0][31:0]      host_regs_data_out;
    logic                   host_regs_valid_out;

    xbox_xlr_dummy1 #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LG)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .xlr_mem_addr          (xlr_mem_addr),
        .xlr_mem_wdata         (xlr_mem_wdata),
        .xlr_mem_be            (xlr_mem_be),
        .xlr_mem_rd            (xlr_mem_rd),
        .xlr_mem_wr            (xlr_mem_wr),
        .xlr_mem_rdata         (xlr_mem_rdata),
        .host_regs             (host_regs),
        .host_regs_valid_pulse (host_regs_valid_pulse),
        .host_regs_data_out    (host_regs_data_out),
        .host_regs_valid_out   (host_regs_valid_out)
    );

    // Behavioural memories: mem0 read data valid the cycle after rd, mem1 written on wr.
    logic [255:0] mem0 [256];
    logic [255:0] mem1 [256];
    logic [255:0] rdata0 = '0;
    assign xlr_mem_rdata = {256'h0, rdata0};

    always @(posedge clk) begin
        if (xlr_mem_rd[0]) rdata0 <= mem0[xlr_mem_addr[0]];
        if (xlr_mem_wr[1]) mem1[xlr_mem_addr[1]] <= xlr_mem_wdata[1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int n_rd = 0, n_wr = 0, n_vld = 0, n_overlap = 0, n_wide = 0;
    int rd_first = -1, vld_cyc = -1;
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    logic [LG-1:0] rd_addr_q[$];

    always @(negedge clk) begin
        if (|xlr_mem_rd) begin
            n_rd++;
            rd_addr_q.push_back(xlr_mem_addr[0]);
            if (rd_first < 0) rd_first = cyc;
        end
        if (|xlr_mem_wr) n_wr++;
        if ((|xlr_mem_rd) && (|xlr_mem_wr)) n_overlap++;
        if ((xlr_mem_rd[0] && prev_rd) || (xlr_mem_wr[1] && prev_wr)) n_wide++;
        prev_rd = xlr_mem_rd[0];
        prev_wr = xlr_mem_wr[1];
        if (host_regs_valid_out) begin
            n_vld++;
            vld_cyc = cyc;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int t_start = 0;

    task automatic issue_start(input logic [31:0] n, input logic [31:0] s, input logic [31:0] k);
        tick();
        host_regs = '0;
        host_regs[0] = 32'd1;
        host_regs[1] = n;
        host_regs[2] = s;
        host_regs[3] = k;
        host_regs_valid_pulse = 1'b1;
        t_start = cyc;
        rd_first = -1;
        rd_addr_q.delete();
        tick();
        host_regs_valid_pulse = 1'b0;
        host_regs = '0;
    endtask

    task automatic wait_valid(input int prev, input int budget);
        int k = 0;
        while (n_vld == prev && k < budget) begin
            tick();
            k++;
        end
        if (n_vld == prev) chk("valid_timeout", 1, 0);
    endtask

    function automatic logic [255:0] mkline(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] l;
        for (int j = 0; j < 8; j++) l[j*32 +: 32] = base + step * j;
        return l;
    endfunction

    function automatic logic any_out();
        return |{xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
                 host_regs_data_out, host_regs_valid_out};
    endfunction

    int rd0, wr0, v0;
    logic [255:0] ovf;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[0]   = mkline(32'h1, 32'h1);       // 1..8
        mem0[1]   = mkline(32'h0, 32'h1);       // 0..7
        mem0[255] = mkline(32'h100, 32'h100);   // 0x100..0x800
        ovf = mkline(32'h8000_0000, 32'h0);
        ovf[31:0] = 32'hFFFF_FFFF;
        mem0[5] = ovf;

        // Reset state
        #1;
        chk("reset_outputs", any_out(), 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_no_strobes", n_rd + n_wr + n_vld, 0);

        // Single line: 1..8 + 0x10
        v0 = n_vld; rd0 = n_rd; wr0 = n_wr;
        issue_start(1, 0, 32'h10);
        wait_valid(v0, 20);
        chk("single_first_rd_cyc", rd_first, t_start + 1);
        chk("single_valid_cyc", vld_cyc, t_start + 4);
        chk("single_mem1_0", mem1[0], mkline(32'h11, 32'h1));
        chk("single_done", host_regs_data_out[0], 1);
        chk("single_checksum", host_regs_data_out[1], 32'hA4);
        chk("single_count", host_regs_data_out[2], 1);
        chk("single_upper_zero", |host_regs_data_out[31:3], 0);
        chk("single_rd_cnt", n_rd - rd0, 1);
        chk("single_wr_cnt", n_wr - wr0, 1);

        // Wrap: lines 255 then 0, K=0
        v0 = n_vld;
        issue_start(2, 255, 0);
        wait_valid(v0, 30);
        chk("wrap_valid_cyc", vld_cyc, t_start + 7);
        chk("wrap_rd_addr0", rd_addr_q.size() > 0 ? rd_addr_q[0] : 8'h55, 8'd255);
        chk("wrap_rd_addr1", rd_addr_q.size() > 1 ? rd_addr_q[1] : 8'h55, 8'd0);
        chk("wrap_mem1_0", mem1[0], mkline(32'h100, 32'h100));
        chk("wrap_mem1_1", mem1[1], mkline(32'h1, 32'h1));
        chk("wrap_checksum", host_regs_data_out[1], 32'h2424);
        chk("wrap_count", host_regs_data_out[2], 2);

        // Overflow: 0xFFFFFFFF + 1 -> 0, checksum 7*0x80000001 mod 2^32
        v0 = n_vld;
        issue_start(1, 5, 1);
        wait_valid(v0, 20);
        chk("ovf_word0", mem1[0][31:0], 0);
        chk("ovf_word1", mem1[0][63:32], 32'h8000_0001);
        chk("ovf_checksum", host_regs_data_out[1], 32'h8000_0007);

        // N=0: no traffic, result next cycle
        v0 = n_vld; rd0 = n_rd; wr0 = n_wr;
        issue_start(0, 7, 32'h55);
        wait_valid(v0, 10);
        chk("n0_valid_cyc", vld_cyc, t_start + 1);
        chk("n0_done", host_regs_data_out[0], 1);
        chk("n0_checksum", host_regs_data_out[1], 0);
        chk("n0_count", host_regs_data_out[2], 0);
        repeat (5) tick();
        chk("n0_no_traffic", (n_rd - rd0) + (n_wr - wr0), 0);

        // Start while busy: second command must vanish
        v0 = n_vld; rd0 = n_rd;
        issue_start(2, 0, 0);
        begin
            int t1;
            t1 = t_start;
            chk("busy_done_cleared", host_regs_data_out[0], 0);
            issue_start(1, 5, 7);
            wait_valid(v0, 30);
            chk("busy_valid_cyc", vld_cyc, t1 + 7);
        end
        chk("busy_checksum", host_regs_data_out[1], 32'h40);
        chk("busy_count", host_regs_data_out[2], 2);
        chk("busy_mem1_1", mem1[1], mkline(32'h0, 32'h1));
        repeat (15) tick();
        chk("busy_one_valid", n_vld - v0, 1);
        chk("busy_rd_cnt", n_rd - rd0, 2);

        // Reset mid-operation aborts everything
        v0 = n_vld;
        issue_start(3, 0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", any_out(), 0);
        #9;
        rst_n = 1'b1;
        rd0 = n_rd; wr0 = n_wr;
        repeat (20) tick();
        chk("midrst_no_strobes", (n_rd - rd0) + (n_wr - wr0), 0);
        chk("midrst_no_valid", n_vld - v0, 0);
        chk("midrst_dout_zero", |host_regs_data_out, 0);

        // Recovers after reset
        v0 = n_vld;
        issue_start(1, 1, 0);
        wait_valid(v0, 20);
        chk("post_rst_checksum", host_regs_data_out[1], 32'h1C);

        chk("rd_wr_overlap", n_overlap, 0);
        chk("strobe_width", n_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
